// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction fetch sequencer for a small (2**ADDR_WIDTH entry) instruction
// memory. It owns the program counter, drives the memory's combinational
// read address, and registers each returned word into a one-entry output
// stage that decode drains through a valid/ready handshake. It handles the
// start pulse, backpressure, branch/jump redirects and halt detection.
//
// Handshake: instr_valid/instr_out/instr_pc are registered. A word transfers
// on a rising edge where instr_valid && instr_ready. While instr_valid is
// high and instr_ready low, the output stage is frozen (no field changes)
// unless a redirect flushes it. A redirect takes priority over everything;
// a same-cycle instr_ready is then treated as consuming the flushed word.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous, active-high reset
//   run             in   start pulse, only sampled in IDLE
//   imem_addr       out  memory read address (= pc)
//   imem_data       in   combinational memory read data for imem_addr
//   redirect_valid  in   load redirect_addr into pc this cycle
//   redirect_addr   in   redirect target
//   instr_valid     out  output stage holds a valid instruction
//   instr_ready     in   decode accepts the instruction this cycle
//   instr_out       out  registered instruction word
//   instr_pc        out  address instr_out was fetched from
//   halted          out  halt instruction consumed, fetching stopped
//   dbg_state       out  current FSM state (IDLE=0, FETCH=1, DRAIN=2, HALT=3)
//
// Optional build macro IMEM_FETCH_PERF_EN adds saturating counters:
//   fetch_count (16b) captures, stall_count (16b) stalled cycles,
//   flush_count (8b) redirects that discarded a valid word.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int                     ADDR_WIDTH  = 5,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   halted,
    output logic [1:0]             dbg_state
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [15:0]            fetch_count,
    output logic [15:0]            stall_count,
    output logic [7:0]             flush_count
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] out_q, out_d;
    logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
    logic                   halted_q, halted_d;

    logic redirect_take;
    logic capture;

    // IDLE only absorbs a redirect into pc; it never flushes or leaves IDLE.
    assign redirect_take = redirect_valid && (state_q != S_IDLE);
    assign capture       = (state_q == S_FETCH) && (!valid_q || instr_ready)
                           && !redirect_valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        out_d    = out_q;
        ipc_d    = ipc_q;
        halted_d = halted_q;

        if (redirect_take) begin
            pc_d     = redirect_addr;
            valid_d  = 1'b0;
            halted_d = 1'b0;
            state_d  = S_FETCH;
        end else if (state_q == S_IDLE) begin
            if (redirect_valid) begin
                pc_d = redirect_addr;
            end
            if (run) begin
                state_d = S_FETCH;
            end
            if (instr_ready) begin
                valid_d = 1'b0;
            end
        end else if (capture) begin
            out_d   = imem_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            // The halt word parks pc on itself so a later redirect is the
            // only way forward.
            if (imem_data == HALT_INSTR) begin
                state_d = S_DRAIN;
            end else begin
                pc_d = pc_q + ADDR_WIDTH'(1);
            end
        end else if (instr_ready) begin
            valid_d = 1'b0;
            if ((state_q == S_DRAIN) && valid_q) begin
                halted_d = 1'b1;
                state_d  = S_HALT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            out_q    <= '0;
            ipc_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
            ipc_q    <= ipc_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr_out   = out_q;
    assign instr_pc    = ipc_q;
    assign halted      = halted_q;
    assign dbg_state   = state_q;

`ifdef IMEM_FETCH_PERF_EN
    // Observation-only counters; they saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (capture && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (valid_q && !instr_ready && (stall_count != '1)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (redirect_take && valid_q && (flush_count != '1)) begin
                flush_count <= flush_count + 8'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic [4:0]  imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [4:0]  instr_pc;
  logic        halted;
  logic [1:0]  dbg_state;
`ifdef IMEM_FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
  logic [7:0]  flush_count;
`endif

  logic [15:0] mem [32];
  assign imem_data = mem[imem_addr];

  int n_vec = 0;
  int n_err = 0;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .halted         (halted),
    .dbg_state      (dbg_state)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: let the rising edge happen, land on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [4:0]  exp_pc;
  logic        exp_halted;
  logic        rd;
  logic        rr;
  logic [4:0]  ra;
  int          n_acc;

  initial begin
    rst = 1'b1;
    run = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    instr_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);

    // reset state
    @(negedge clk);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_out", instr_out, 0);
    check("rst_ipc", instr_pc, 0);
    check("rst_addr", imem_addr, 0);

    // IDLE: no captures without run
    rst = 1'b0;
    instr_ready = 1'b1;
    step();
    check("idle_valid", instr_valid, 0);

    // streaming: first valid two edges after run
    run = 1'b1;
    step();
    run = 1'b0;
    check("first_valid_early", instr_valid, 0);
    step();
    check("first_valid", instr_valid, 1);
    check("first_out", instr_out, 16'h1000);
    check("first_pc", instr_pc, 0);
    for (int k = 1; k < 4; k++) begin
      step();
      check("stream_valid", instr_valid, 1);
      check("stream_out", instr_out, 32'h1000 + k);
      check("stream_pc", instr_pc, k);
    end

    // backpressure on 0x1004
    step();
    check("bp_out0", instr_out, 16'h1004);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_valid", instr_valid, 1);
      check("bp_out", instr_out, 16'h1004);
      check("bp_pc", instr_pc, 4);
      check("bp_addr", imem_addr, 5);
    end
    instr_ready = 1'b1;
    step();
    check("bp_release_out", instr_out, 16'h1005);
    check("bp_release_pc", instr_pc, 5);

    // redirect during stall
    instr_ready = 1'b0;
    step();
    check("stall_out", instr_out, 16'h1005);
    redirect_valid = 1'b1;
    redirect_addr = 5'd12;
    step();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    check("flush_valid", instr_valid, 0);
    check("flush_addr", imem_addr, 12);
    step();
    check("redir_valid", instr_valid, 1);
    check("redir_out", instr_out, 16'h100C);
    check("redir_pc", instr_pc, 12);

    // wrap 30, 31, 0, 1
    redirect_valid = 1'b1;
    redirect_addr = 5'd30;
    step();
    redirect_valid = 1'b0;
    check("wrap_flush", instr_valid, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("wrap_valid", instr_valid, 1);
      check("wrap_pc", instr_pc, (30 + k) % 32);
      check("wrap_out", instr_out, 32'h1000 + ((30 + k) % 32));
    end

    // halt at address 3
    mem[3] = 16'hFFFF;
    redirect_valid = 1'b1;
    redirect_addr = 5'd0;
    step();
    redirect_valid = 1'b0;
    check("halt_flush", instr_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_pre_pc", instr_pc, k);
    end
    step();
    check("halt_word", instr_out, 16'hFFFF);
    check("halt_word_pc", instr_pc, 3);
    check("halt_not_yet", halted, 0);
    instr_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("drain_valid", instr_valid, 1);
      check("drain_out", instr_out, 16'hFFFF);
      check("drain_halted", halted, 0);
      check("drain_addr", imem_addr, 3);
    end
    instr_ready = 1'b1;
    step();
    check("halted_set", halted, 1);
    check("halted_valid", instr_valid, 0);
    run = 1'b1;
    step();
    run = 1'b0;
    check("halted_run_ignored", halted, 1);
    check("halted_no_capture", instr_valid, 0);
    check("halted_addr", imem_addr, 3);
    step();
    check("halted_still", halted, 1);
    check("halted_still_valid", instr_valid, 0);

    // redirect out of HALT
    redirect_valid = 1'b1;
    redirect_addr = 5'd0;
    step();
    redirect_valid = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_flush", instr_valid, 0);
    step();
    check("resume_out", instr_out, 16'h1000);
    check("resume_pc", instr_pc, 0);
    step();
    check("resume_pc1", instr_pc, 1);
    check("resume_valid1", instr_valid, 1);

    // reset mid-fetch with a valid word: clears immediately
    rst = 1'b1;
    #1;
    check("amid_valid", instr_valid, 0);
    check("amid_halted", halted, 0);
    check("amid_ipc", instr_pc, 0);
    check("amid_out", instr_out, 0);
    check("amid_addr", imem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("amid_idle", instr_valid, 0);

    // randomized phase against a transaction-level model:
    // the word on display is always mem[exp_pc]; acceptance advances exp_pc,
    // a halt word acceptance stops everything until a redirect.
    for (int i = 0; i < 32; i++)
      mem[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
    run = 1'b1;
    step();
    run = 1'b0;
    exp_pc = 5'd0;
    exp_halted = 1'b0;
    n_acc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_halted", halted, exp_halted);
      if (exp_halted) check("rnd_halted_valid", instr_valid, 0);
      if (instr_valid) begin
        check("rnd_out", instr_out, mem[exp_pc]);
        check("rnd_pc", instr_pc, exp_pc);
      end
      rr = ($urandom_range(0, 3) != 0);
      rd = exp_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
      ra = 5'($urandom_range(0, 31));
      instr_ready = rr;
      redirect_valid = rd;
      redirect_addr = ra;
      if (rd) begin
        exp_pc = ra;
        exp_halted = 1'b0;
      end else if (instr_valid && rr) begin
        n_acc++;
        if (mem[exp_pc] == 16'hFFFF) exp_halted = 1'b1;
        else exp_pc = exp_pc + 5'd1;
      end
      step();
    end
    redirect_valid = 1'b0;
    check("rnd_progress", (n_acc > 200) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
